pic_cascade_ctrl: RTL and testbench



---
 rtl/pic_cascade_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pic_cascade_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pic_cascade_ctrl.sv
// Cascade controller for a master/slave 8259 pair: programs both PICs after reset,
// passes CPU port accesses through, and sequences the interrupt-acknowledge handshake.
module pic_cascade_ctrl #(
   parameter logic [7:0] MASTER_BASE   = 8'h08,
   parameter logic [7:0] SLAVE_BASE    = 8'h70,
   parameter int         CASCADE_IRQ   = 2,
   parameter logic [7:0] MASTER_MASK   = 8'h00,
   parameter logic [7:0] SLAVE_MASK    = 8'h00,
   parameter int         AUTO_INIT     = 1,
   parameter int         SLAVE_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_cpu_io_sel,
   input  logic       i_cpu_io_address,
   input  logic       i_cpu_io_read,
   input  logic       i_cpu_io_write,
   input  logic [7:0] i_cpu_io_writedata,
   output logic [7:0] o_cpu_io_readdata,
   output logic       o_cpu_io_ready,
   output logic       o_m_io_address,
   output logic       o_m_io_read,
   output logic       o_m_io_write,
   output logic [7:0] o_m_io_writedata,
   input  logic [7:0] i_m_io_readdata,
   output logic       o_s_io_address,
   output logic       o_s_io_read,
   output logic       o_s_io_write,
   output logic [7:0] o_s_io_writedata,
   input  logic [7:0] i_s_io_readdata,
   input  logic       i_m_int_valid,
   input  logic [7:0] i_m_int_data,
   input  logic       i_m_slave_active,
   output logic       o_m_int_ack,
   input  logic       i_s_int_valid,
   input  logic [7:0] i_s_int_data,
   output logic       o_s_int_ack,
   output logic       o_cascade_irq,
   output logic       o_cpu_int_valid,
   output logic [7:0] o_cpu_int_vector,
   input  logic       i_cpu_int_ack
);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_S_WAIT, ST_PRESENT} state_t;

   localparam state_t     RESET_STATE  = (AUTO_INIT != 0) ? ST_INIT : ST_IDLE;
   localparam logic [7:0] CASCADE_BIT  = 8'(8'd1 << CASCADE_IRQ);
   localparam logic [7:0] TIMEOUT_LAST = 8'(SLAVE_TIMEOUT - 1);
   localparam logic [7:0] SPURIOUS_VEC = {SLAVE_BASE[7:3], 3'd7};

   state_t     r_state;
   logic [3:0] r_k;
   logic [7:0] r_cnt;
   logic [7:0] r_vector;

   logic       w_init_slave;
   logic       w_init_addr;
   logic [7:0] w_init_data;

   // Main sequencer: init steps, master/slave acknowledge and CPU presentation
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state  <= RESET_STATE;
         r_k      <= 4'd0;
         r_cnt    <= 8'd0;
         r_vector <= 8'h00;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_k == 4'd9) begin
                  r_k     <= 4'd0;
                  r_state <= ST_IDLE;
               end else begin
                  r_k <= r_k + 4'd1;
               end
            end
            ST_IDLE: begin
               // The ack pulses this cycle, so data and slave_active are taken together
               if (i_m_int_valid) begin
                  if (i_m_slave_active) begin
                     r_cnt   <= 8'd0;
                     r_state <= ST_S_WAIT;
                  end else begin
                     r_vector <= i_m_int_data;
                     r_state  <= ST_PRESENT;
                  end
               end
            end
            ST_S_WAIT: begin
               if (i_s_int_valid) begin
                  r_vector <= i_s_int_data;
                  r_state  <= ST_PRESENT;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  r_vector <= SPURIOUS_VEC;
                  r_state  <= ST_PRESENT;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_PRESENT: begin
               if (i_cpu_int_ack) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= RESET_STATE;
         endcase
      end
   end

   // Fixed ICW1..ICW4 + OCW1 program, master in steps 0-4 and slave in steps 5-9
   always_comb begin
      w_init_slave = 1'b0;
      w_init_addr  = 1'b0;
      w_init_data  = 8'h00;
      case (r_k)
         4'd0: begin w_init_slave = 1'b0; w_init_addr = 1'b0; w_init_data = 8'h11;        end
         4'd1: begin w_init_slave = 1'b0; w_init_addr = 1'b1; w_init_data = MASTER_BASE;  end
         4'd2: begin w_init_slave = 1'b0; w_init_addr = 1'b1; w_init_data = CASCADE_BIT;  end
         4'd3: begin w_init_slave = 1'b0; w_init_addr = 1'b1; w_init_data = 8'h01;        end
         4'd4: begin w_init_slave = 1'b0; w_init_addr = 1'b1; w_init_data = MASTER_MASK;  end
         4'd5: begin w_init_slave = 1'b1; w_init_addr = 1'b0; w_init_data = 8'h11;        end
         4'd6: begin w_init_slave = 1'b1; w_init_addr = 1'b1; w_init_data = SLAVE_BASE;   end
         4'd7: begin w_init_slave = 1'b1; w_init_addr = 1'b1; w_init_data = 8'h00;        end
         4'd8: begin w_init_slave = 1'b1; w_init_addr = 1'b1; w_init_data = 8'h01;        end
         4'd9: begin w_init_slave = 1'b1; w_init_addr = 1'b1; w_init_data = SLAVE_MASK;   end
         default: begin w_init_slave = 1'b0; w_init_addr = 1'b0; w_init_data = 8'h00;     end
      endcase
   end

   // Port steering: init writes or CPU pass-through; everything quiet while in reset
   always_comb begin
      o_m_io_address   = 1'b0;
      o_m_io_read      = 1'b0;
      o_m_io_write     = 1'b0;
      o_m_io_writedata = 8'h00;
      o_s_io_address   = 1'b0;
      o_s_io_read      = 1'b0;
      o_s_io_write     = 1'b0;
      o_s_io_writedata = 8'h00;
      if (!resetn) begin
         o_m_io_write = 1'b0;
      end else if (r_state == ST_INIT) begin
         if (w_init_slave) begin
            o_s_io_address   = w_init_addr;
            o_s_io_write     = 1'b1;
            o_s_io_writedata = w_init_data;
         end else begin
            o_m_io_address   = w_init_addr;
            o_m_io_write     = 1'b1;
            o_m_io_writedata = w_init_data;
         end
      end else if (i_cpu_io_sel) begin
         o_s_io_address   = i_cpu_io_address;
         o_s_io_read      = i_cpu_io_read;
         o_s_io_write     = i_cpu_io_write;
         o_s_io_writedata = i_cpu_io_writedata;
      end else begin
         o_m_io_address   = i_cpu_io_address;
         o_m_io_read      = i_cpu_io_read;
         o_m_io_write     = i_cpu_io_write;
         o_m_io_writedata = i_cpu_io_writedata;
      end
   end

   assign o_cpu_io_readdata = i_cpu_io_sel ? i_s_io_readdata : i_m_io_readdata;
   assign o_cpu_io_ready    = (r_state != ST_INIT);
   assign o_cascade_irq     = i_s_int_valid;
   assign o_m_int_ack       = resetn && (r_state == ST_IDLE)   && i_m_int_valid;
   assign o_s_int_ack       = resetn && (r_state == ST_S_WAIT) && i_s_int_valid;
   assign o_cpu_int_valid   = (r_state == ST_PRESENT);
   assign o_cpu_int_vector  = r_vector;

endmodule

// File: tb/tb_pic_cascade_ctrl.sv
// Randomized self-checking bench for pic_cascade_ctrl with a rule-level reference model.
module tb_pic_cascade_ctrl;

   localparam logic [7:0] MB   = 8'h08;
   localparam logic [7:0] SB   = 8'h70;
   localparam int         TMO  = 16;
   localparam logic [7:0] SPUR = 8'h77;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cpu_sel = 1'b0, cpu_addr = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [7:0] cpu_wdata = 8'h00;
   logic [7:0] cpu_rdata;
   logic       cpu_ready;
   logic       m_addr, m_rd, m_wr, s_addr, s_rd, s_wr;
   logic [7:0] m_wdata, s_wdata;
   logic [7:0] m_rdata = 8'h00, s_rdata = 8'h00;
   logic       m_valid = 1'b0, m_sa = 1'b0, s_valid = 1'b0;
   logic [7:0] m_data = 8'h00, s_data = 8'h00;
   logic       m_ack, s_ack, casc_irq, cpu_valid;
   logic [7:0] cpu_vec;
   logic       cpu_ack = 1'b0;

   int total = 0;
   int bad   = 0;

   pic_cascade_ctrl dut (
      .clk(clk), .resetn(resetn),
      .i_cpu_io_sel(cpu_sel), .i_cpu_io_address(cpu_addr), .i_cpu_io_read(cpu_rd),
      .i_cpu_io_write(cpu_wr), .i_cpu_io_writedata(cpu_wdata),
      .o_cpu_io_readdata(cpu_rdata), .o_cpu_io_ready(cpu_ready),
      .o_m_io_address(m_addr), .o_m_io_read(m_rd), .o_m_io_write(m_wr),
      .o_m_io_writedata(m_wdata), .i_m_io_readdata(m_rdata),
      .o_s_io_address(s_addr), .o_s_io_read(s_rd), .o_s_io_write(s_wr),
      .o_s_io_writedata(s_wdata), .i_s_io_readdata(s_rdata),
      .i_m_int_valid(m_valid), .i_m_int_data(m_data), .i_m_slave_active(m_sa),
      .o_m_int_ack(m_ack), .i_s_int_valid(s_valid), .i_s_int_data(s_data),
      .o_s_int_ack(s_ack), .o_cascade_irq(casc_irq),
      .o_cpu_int_valid(cpu_valid), .o_cpu_int_vector(cpu_vec), .i_cpu_int_ack(cpu_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic rand_cpu();
      cpu_sel   = 1'($urandom);
      cpu_addr  = 1'($urandom);
      cpu_rd    = 1'($urandom);
      cpu_wr    = 1'($urandom);
      cpu_wdata = 8'($urandom);
      m_rdata   = 8'($urandom);
      s_rdata   = 8'($urandom);
   endtask

   // Pass-through rules: selected PIC mirrors the CPU, unselected sees no strobes
   task automatic chk_pass();
      chk("ready", 32'(cpu_ready), 32'd1);
      chk("rdata", 32'(cpu_rdata), 32'(cpu_sel ? s_rdata : m_rdata));
      chk("m_rd", 32'(m_rd), 32'(!cpu_sel && cpu_rd));
      chk("m_wr", 32'(m_wr), 32'(!cpu_sel && cpu_wr));
      chk("s_rd", 32'(s_rd), 32'(cpu_sel && cpu_rd));
      chk("s_wr", 32'(s_wr), 32'(cpu_sel && cpu_wr));
      if (cpu_sel) begin
         chk("s_addr", 32'(s_addr), 32'(cpu_addr));
         chk("s_wdata", 32'(s_wdata), 32'(cpu_wdata));
      end else begin
         chk("m_addr", 32'(m_addr), 32'(cpu_addr));
         chk("m_wdata", 32'(m_wdata), 32'(cpu_wdata));
      end
      chk("casc_irq", 32'(casc_irq), 32'(s_valid));
   endtask

   task automatic chk_reset_state();
      chk("rst_valid", 32'(cpu_valid), 32'd0);
      chk("rst_vec", 32'(cpu_vec), 32'd0);
      chk("rst_mack", 32'(m_ack), 32'd0);
      chk("rst_sack", 32'(s_ack), 32'd0);
      chk("rst_ready", 32'(cpu_ready), 32'd0);
      chk("rst_strobes", 32'({m_rd, m_wr, s_rd, s_wr}), 32'd0);
   endtask

   // Release reset and check the ten programming writes cycle by cycle
   task automatic run_init();
      logic [7:0] prog [10];
      prog = '{8'h11, MB, 8'h04, 8'h01, 8'h00, 8'h11, SB, 8'h00, 8'h01, 8'h00};
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         resetn  = 1'b1;
         rand_cpu();
         m_valid = 1'($urandom);
         m_data  = 8'($urandom);
         m_sa    = 1'($urandom);
         @(negedge clk);
         chk("init_ready", 32'(cpu_ready), 32'd0);
         chk("init_mack", 32'(m_ack), 32'd0);
         chk("init_reads", 32'({m_rd, s_rd}), 32'd0);
         chk("init_m_wr", 32'(m_wr), 32'(k < 5));
         chk("init_s_wr", 32'(s_wr), 32'(k >= 5));
         if (k < 5) begin
            chk("init_m_addr", 32'(m_addr), 32'((k % 5) != 0));
            chk("init_m_data", 32'(m_wdata), 32'(prog[k]));
         end else begin
            chk("init_s_addr", 32'(s_addr), 32'((k % 5) != 0));
            chk("init_s_data", 32'(s_wdata), 32'(prog[k]));
         end
      end
      @(posedge clk); #1;
      m_valid = 1'b0;
      m_sa    = 1'b0;
      rand_cpu();
      @(negedge clk);
      chk("init_done_mack", 32'(m_ack), 32'd0);
      chk_pass();
   endtask

   task automatic run_io(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         rand_cpu();
         @(negedge clk);
         chk_pass();
      end
   endtask

   // One interrupt: casc selects a slave-routed IRQ, j is the S_WAIT cycle (1-based)
   // in which the slave vector first appears, dly is how long the CPU holds off its ack
   task automatic run_irq(input bit casc, input int j, input int dly);
      logic [7:0] md, sd, ev;
      bit got;
      md  = 8'($urandom);
      sd  = 8'($urandom);
      ev  = !casc ? md : ((j <= TMO) ? sd : SPUR);
      got = 1'b0;
      @(posedge clk); #1;
      m_valid = 1'b1; m_data = md; m_sa = casc; cpu_ack = 1'($urandom);
      @(negedge clk);
      chk("t_mack", 32'(m_ack), 32'd1);
      chk("t_sack", 32'(s_ack), 32'd0);
      chk("t_valid", 32'(cpu_valid), 32'd0);
      if (casc) begin
         for (int c = 1; c <= TMO && !got; c++) begin
            @(posedge clk); #1;
            m_valid = 1'($urandom); m_data = 8'($urandom); m_sa = 1'($urandom);
            cpu_ack = 1'($urandom);
            s_valid = (c >= j); s_data = sd;
            @(negedge clk);
            chk("wait_sack", 32'(s_ack), 32'(c == j));
            chk("wait_mack", 32'(m_ack), 32'd0);
            chk("wait_valid", 32'(cpu_valid), 32'd0);
            chk("wait_casc", 32'(casc_irq), 32'(s_valid));
            got = (c == j);
         end
      end
      for (int c = 0; c <= dly; c++) begin
         @(posedge clk); #1;
         s_valid = 1'($urandom); s_data = 8'($urandom);
         m_valid = 1'($urandom); m_data = 8'($urandom); m_sa = 1'($urandom);
         cpu_ack = (c == dly);
         @(negedge clk);
         chk("pres_valid", 32'(cpu_valid), 32'd1);
         chk("pres_vector", 32'(cpu_vec), 32'(ev));
         chk("pres_mack", 32'(m_ack), 32'd0);
         chk("pres_sack", 32'(s_ack), 32'd0);
      end
      @(posedge clk); #1;
      m_valid = 1'b0; m_sa = 1'b0; s_valid = 1'b0; cpu_ack = 1'($urandom);
      @(negedge clk);
      chk("after_valid", 32'(cpu_valid), 32'd0);
      chk("after_vector", 32'(cpu_vec), 32'(ev));
      chk("after_mack", 32'(m_ack), 32'd0);
      cpu_ack = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         rand_cpu();
         m_valid = 1'($urandom);
         @(negedge clk);
         if (i > 0) chk_reset_state();
      end
      run_init();
      run_io(20);

      run_irq(1'b0, 0, 0);
      run_irq(1'b0, 0, 20);
      run_irq(1'b1, 1, 0);
      run_irq(1'b1, TMO, 3);
      run_irq(1'b1, TMO + 1, 2);
      run_irq(1'b1, 200, 0);
      for (int n = 0; n < 40; n++) begin
         run_irq(1'($urandom), int'($urandom_range(1, TMO + 4)), int'($urandom_range(0, 20)));
         if ((n % 8) == 0) run_io(5);
      end

      // Reset taken while a vector is being presented
      @(posedge clk); #1;
      m_valid = 1'b1; m_data = 8'h09; m_sa = 1'b0;
      @(negedge clk);
      chk("pre_rst_mack", 32'(m_ack), 32'd1);
      @(posedge clk); #1;
      m_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", 32'(cpu_valid), 32'd1);
      chk("pre_rst_vec", 32'(cpu_vec), 32'h09);
      @(posedge clk); #1;
      resetn = 1'b0;
      @(negedge clk);
      chk("rst_in_mack", 32'(m_ack), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_reset_state();
      run_init();
      run_irq(1'b1, 4, 1);
      run_io(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
